// File: rtl/kb_event_sequencer.sv
// rtl/kb_event_sequencer.sv - PS/2 scan code parser, typematic filter and FWFT key event queue
module kb_event_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        scan_code,
    input  logic              scan_done_tick,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [7:0]        ev_code,
    output logic              ev_ext,
    output logic              ev_break,
    output logic [ADDR_W:0]   ev_count,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic              key_held,
    output logic [7:0]        held_code,
    output logic              held_ext
);
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t          state;
    state_t          state_n;
    logic [TO_W-1:0] to_cnt;

    logic            ev_gen;
    logic            ev_gen_ext;
    logic            ev_gen_brk;
    logic            is_noise;
    logic            held_match;
    logic            push_req;

    logic [9:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    // Controller chatter (BAT result, ACK, resend, errors) is only meaningful outside a sequence
    assign is_noise = scan_code inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};

    always_comb begin
        state_n    = state;
        ev_gen     = 1'b0;
        ev_gen_ext = 1'b0;
        ev_gen_brk = 1'b0;
        if (scan_done_tick) begin
            case (state)
                IDLE: begin
                    if (scan_code == 8'hE0) begin
                        state_n = EXT;
                    end else if (scan_code == 8'hF0) begin
                        state_n = BRK;
                    end else if (!is_noise) begin
                        ev_gen = 1'b1;
                    end
                end
                EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_n = EXT_BRK;
                    end else if (scan_code != 8'hE0) begin
                        ev_gen     = 1'b1;
                        ev_gen_ext = 1'b1;
                        state_n    = IDLE;
                    end
                end
                BRK: begin
                    if (scan_code == 8'hE0) begin
                        state_n = EXT;
                    end else if (scan_code != 8'hF0) begin
                        ev_gen     = 1'b1;
                        ev_gen_brk = 1'b1;
                        state_n    = IDLE;
                    end
                end
                default: begin
                    if (scan_code != 8'hE0 && scan_code != 8'hF0) begin
                        ev_gen     = 1'b1;
                        ev_gen_ext = 1'b1;
                        ev_gen_brk = 1'b1;
                        state_n    = IDLE;
                    end
                end
            endcase
        end else if (state != IDLE && to_cnt == TO_LAST) begin
            state_n = IDLE;
        end
    end

    assign held_match = key_held && (scan_code == held_code) && (ev_gen_ext == held_ext);
    // A repeated make of the key already held is typematic and never reaches the queue
    assign push_req   = ev_gen && (ev_gen_brk || !held_match);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            to_cnt    <= '0;
            key_held  <= 1'b0;
            held_code <= 8'h00;
            held_ext  <= 1'b0;
        end else begin
            state <= state_n;
            if (scan_done_tick || state_n == IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (ev_gen && !ev_gen_brk && !held_match) begin
                key_held  <= 1'b1;
                held_code <= scan_code;
                held_ext  <= ev_gen_ext;
            end else if (ev_gen && ev_gen_brk && held_match) begin
                key_held <= 1'b0;
            end
        end
    end

    assign ev_valid = (ev_count != '0);
    assign full     = (ev_count == DEPTH);
    assign pop      = ev_valid && ev_ready;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ev_gen_ext, ev_gen_brk, scan_code};
        end
    end

    assign {ev_ext, ev_break, ev_code} = ev_valid ? mem[rd_ptr] : 10'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   ev_count <= ev_count + (ADDR_W + 1)'(1);
                2'b01:   ev_count <= ev_count - (ADDR_W + 1)'(1);
                default: ev_count <= ev_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule
